// File: rtl/key_port_pkg.sv
// rtl/key_port_pkg.sv - shared constants and helpers for the debounced key port
package key_port_pkg;

   localparam int KEY_BITS         = 3;
   localparam int DB_COUNT_DEFAULT = 500000;   // 10 ms at 50 MHz
   localparam int CNT_W_DEFAULT    = 19;

   localparam logic [1:0] OFF_LEVEL = 2'd0;
   localparam logic [1:0] OFF_EDGE  = 2'd1;
   localparam logic [1:0] OFF_MASK  = 2'd2;

   // Place a per-key vector at bits [3:1], matching the legacy KEY read layout
   function automatic logic [15:0] pack_keys(input logic [KEY_BITS-1:0] k);
      return {12'd0, k, 1'b0};
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, stability counter and accepted level for one key
module key_debounce
   import key_port_pkg::*;
#(
   parameter int DB_COUNT = DB_COUNT_DEFAULT,
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic key_in,
   output logic level_o,
   output logic press_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

   logic             meta_q, sync_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             differ, accept;

   // Two-flop synchronizer; resets to the released (high) level
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= key_in;
         sync_q <= meta_q;
      end
   end

   // Count consecutive cycles of disagreement; accept the new level on the last one
   always_comb begin
      differ  = (sync_q != level_q);
      accept  = differ && (cnt_q == LAST);
      cnt_d   = '0;
      level_d = level_q;
      if (accept) begin
         level_d = sync_q;
      end else if (differ) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Accepted level and counter state
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   // Combinational so the parent's edge register sets on the same edge as level_q
   assign press_o = accept && !sync_q;

endmodule

// File: rtl/key_edge_port.sv
// rtl/key_edge_port.sv - memory-mapped debounced KEY[3:1] port with press-edge capture
// Optional interrupt mask and irq output enabled by defining KEY_PORT_IRQ_EN.
module key_edge_port
   import key_port_pkg::*;
#(
   parameter int DB_COUNT = DB_COUNT_DEFAULT,
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic [KEY_BITS-1:0] KEY_in,
   input  logic                cs,
   input  logic                W,
   input  logic [1:0]          addr,
   input  logic [15:0]         wdata,
   output logic [15:0]         rdata
`ifdef KEY_PORT_IRQ_EN
   ,
   output logic                irq
`endif
);

   logic [KEY_BITS-1:0] level, press;
   logic [KEY_BITS-1:0] edge_q, edge_d, clr;
   logic                unused_wdata;

   assign unused_wdata = ^{wdata[15:4], wdata[0]};

   for (genvar i = 0; i < KEY_BITS; i++) begin : g_key
      key_debounce #(
         .DB_COUNT (DB_COUNT),
         .CNT_W    (CNT_W)
      ) u_db (
         .Clock   (Clock),
         .Resetn  (Resetn),
         .key_in  (KEY_in[i]),
         .level_o (level[i]),
         .press_o (press[i])
      );
   end

   // Write-1-to-clear on the edge register; a simultaneous press overrides the clear
   always_comb begin
      clr = '0;
      if (cs && W && (addr == OFF_EDGE)) begin
         clr = wdata[3:1];
      end
      edge_d = (edge_q & ~clr) | press;
   end

   // Sticky press-edge bits
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         edge_q <= '0;
      end else begin
         edge_q <= edge_d;
      end
   end

`ifdef KEY_PORT_IRQ_EN
   logic [KEY_BITS-1:0] mask_q, mask_d;
   logic                irq_q;

   // Mask register is plain read/write at its offset
   always_comb begin
      mask_d = mask_q;
      if (cs && W && (addr == OFF_MASK)) begin
         mask_d = wdata[3:1];
      end
   end

   // Mask and registered interrupt; irq lags edge/mask by one cycle
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= |(edge_q & mask_q);
      end
   end

   assign irq = irq_q;
`endif

   // Side-effect-free read mux; unused offsets and bits read as zero
   always_comb begin
      rdata = '0;
      case (addr)
         OFF_LEVEL: rdata = pack_keys(~level);
         OFF_EDGE:  rdata = pack_keys(edge_q);
`ifdef KEY_PORT_IRQ_EN
         OFF_MASK:  rdata = pack_keys(mask_q);
`endif
         default:   rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_key_edge_port.sv
// tb/tb_key_edge_port.sv - directed self-checking bench for key_edge_port
module tb_key_edge_port;

   localparam int DB = 4;

   logic        Clock;
   logic        Resetn;
   logic [2:0]  KEY_in;
   logic        cs;
   logic        W;
   logic [1:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
`ifdef KEY_PORT_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   key_edge_port #(
      .DB_COUNT (DB),
      .CNT_W    (3)
   ) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .KEY_in (KEY_in),
      .cs     (cs),
      .W      (W),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata)
`ifdef KEY_PORT_IRQ_EN
      ,
      .irq    (irq)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Advance n rising edges, leaving time 1 unit past the last edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [15:0] v);
      addr = a;
      #1;
      v = rdata;
   endtask

   // One-cycle register write
   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cs = 1'b1; W = 1'b1; addr = a; wdata = d;
      tick(1);
      cs = 1'b0; W = 1'b0; wdata = '0;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      Resetn = 1'b0; KEY_in = 3'b111; cs = 1'b0; W = 1'b0; addr = '0; wdata = '0;
      tick(2);
      for (int a = 0; a < 4; a++) begin
         rd(a[1:0], v);
         n_checks++;
         if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_hold_off%0d: got %h want %h", a, v, 16'h0000); end
      end
      Resetn = 1'b1;
      tick(3);
      for (int a = 0; a < 4; a++) begin
         rd(a[1:0], v);
         n_checks++;
         if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_idle_off%0d: got %h want %h", a, v, 16'h0000); end
      end
`ifdef KEY_PORT_IRQ_EN
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
   endtask

   task automatic test_press;
      logic [15:0] v;
      KEY_in = 3'b110;
      tick(5);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL press_early: got %h want %h", v, 16'h0000); end
      tick(1);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL press_level: got %h want %h", v, 16'h0002); end
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL press_edge: got %h want %h", v, 16'h0002); end
      tick(4);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL press_held: got %h want %h", v, 16'h0002); end
      KEY_in = 3'b111;
      tick(6);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL release_level: got %h want %h", v, 16'h0000); end
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL release_edge_kept: got %h want %h", v, 16'h0002); end
      wr(2'd1, 16'h0002);
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL press_w1c: got %h want %h", v, 16'h0000); end
   endtask

   task automatic test_glitch;
      logic [15:0] v;
      KEY_in = 3'b101;
      tick(2);
      KEY_in = 3'b111;
      tick(8);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch2_level: got %h want %h", v, 16'h0000); end
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch2_edge: got %h want %h", v, 16'h0000); end
      // Longest pulse that must still be rejected: DB-1 cycles
      KEY_in = 3'b011;
      tick(DB - 1);
      KEY_in = 3'b111;
      tick(8);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch3_level: got %h want %h", v, 16'h0000); end
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch3_edge: got %h want %h", v, 16'h0000); end
   endtask

   task automatic test_multi_and_writes;
      logic [15:0] v;
      KEY_in = 3'b000;
      tick(6);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h000E) begin n_fail++; $display("FAIL multi_level: got %h want %h", v, 16'h000E); end
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h000E) begin n_fail++; $display("FAIL multi_edge: got %h want %h", v, 16'h000E); end
      // cs low: write strobe must be ignored
      cs = 1'b0; W = 1'b1; addr = 2'd1; wdata = 16'h000E;
      tick(1);
      W = 1'b0; wdata = '0;
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h000E) begin n_fail++; $display("FAIL nocs_write: got %h want %h", v, 16'h000E); end
      wr(2'd0, 16'h000E);
      wr(2'd3, 16'h000E);
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h000E) begin n_fail++; $display("FAIL off0_off3_write: got %h want %h", v, 16'h000E); end
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h000E) begin n_fail++; $display("FAIL off0_after_write: got %h want %h", v, 16'h000E); end
      rd(2'd3, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL off3_read: got %h want %h", v, 16'h0000); end
`ifndef KEY_PORT_IRQ_EN
      wr(2'd2, 16'h000E);
      rd(2'd2, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL off2_nomask: got %h want %h", v, 16'h0000); end
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h000E) begin n_fail++; $display("FAIL off2_write_edge: got %h want %h", v, 16'h000E); end
`endif
      // wdata bit 2 clears only the key-2 edge bit
      wr(2'd1, 16'h0004);
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h000A) begin n_fail++; $display("FAIL w1c_key2: got %h want %h", v, 16'h000A); end
      KEY_in = 3'b111;
      tick(6);
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL multi_release: got %h want %h", v, 16'h0000); end
   endtask

   task automatic test_set_wins;
      logic [15:0] v;
      KEY_in = 3'b101;
      tick(5);
      // This write lands on the same edge as the key-2 press event
      wr(2'd1, 16'h0004);
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h000E) begin n_fail++; $display("FAIL set_wins: got %h want %h", v, 16'h000E); end
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0004) begin n_fail++; $display("FAIL set_wins_level: got %h want %h", v, 16'h0004); end
      KEY_in = 3'b111;
      tick(6);
   endtask

`ifdef KEY_PORT_IRQ_EN
   task automatic test_irq;
      logic [15:0] v;
      wr(2'd1, 16'h000E);
      wr(2'd2, 16'h0008);
      rd(2'd2, v);
      n_checks++;
      if (v !== 16'h0008) begin n_fail++; $display("FAIL mask_read: got %h want %h", v, 16'h0008); end
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b want 0", irq); end
      KEY_in = 3'b011;
      tick(6);
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0008) begin n_fail++; $display("FAIL irq_edge: got %h want %h", v, 16'h0008); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b want 0", irq); end
      tick(1);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
      wr(2'd1, 16'h0008);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_clr_lag: got %b want 1", irq); end
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b want 0", irq); end
      KEY_in = 3'b111;
      tick(6);
      wr(2'd1, 16'h000E);
      wr(2'd1, 16'h000E);
      wr(2'd1, 16'h000E);
      KEY_in = 3'b101;
      tick(6);
      wr(2'd1, 16'h0000);
      KEY_in = 3'b111;
      tick(6);
   endtask
`endif

   task automatic test_reset_mid;
      logic [15:0] v;
      rd(2'd1, v);
      n_checks++;
      if (v === 16'h0000) begin n_fail++; $display("FAIL reset_mid_pre: got %h want nonzero", v); end
      KEY_in = 3'b110;
      tick(4);
      // Mid-cycle assertion, no clock edge involved
      #2;
      Resetn = 1'b0;
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL async_reset_edge: got %h want %h", v, 16'h0000); end
      tick(2);
      Resetn = 1'b1;
      tick(DB + 1);
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_early: got %h want %h", v, 16'h0000); end
      tick(1);
      rd(2'd1, v);
      n_checks++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL reset_mid_press: got %h want %h", v, 16'h0002); end
      rd(2'd0, v);
      n_checks++;
      if (v !== 16'h0002) begin n_fail++; $display("FAIL reset_mid_level: got %h want %h", v, 16'h0002); end
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_multi_and_writes();
      test_set_wins();
`ifdef KEY_PORT_IRQ_EN
      test_irq();
      wr(2'd1, 16'h0000);
      KEY_in = 3'b000;
      tick(6);
      KEY_in = 3'b111;
      tick(6);
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
